eth_frame_sched: RTL and testbench

ETH_FRAME_SCHED -- requirements
Module: eth_frame_sched

---
 rtl/eth_frame_sched_if.sv | 28 ++
 rtl/eth_frame_sched.sv | 162 ++++++++++++++++
 tb/tb_eth_frame_sched.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_sched_if.sv
// Requester and receiver signal bundle for eth_frame_sched.
// slave is the scheduler side; master is the requester/receiver side.
interface eth_frame_sched_if #(
   parameter int unsigned N_REQ = 2
) ();
   logic [N_REQ-1:0]    frm_req;
   logic [16*N_REQ-1:0] frm_len;
   logic [8*N_REQ-1:0]  pl_data;
   logic [N_REQ-1:0]    pl_valid;
   logic [N_REQ-1:0]    pl_ready;
   logic [N_REQ-1:0]    gnt;
   logic                rx_ready;
   logic                rx_start;
   logic [7:0]          rx_data;
   logic                busy;
   logic                frame_done;
   logic                frame_err;

   modport master (
      output frm_req, frm_len, pl_data, pl_valid, rx_ready,
      input  pl_ready, gnt, rx_start, rx_data, busy, frame_done, frame_err
   );

   modport slave (
      input  frm_req, frm_len, pl_data, pl_valid, rx_ready,
      output pl_ready, gnt, rx_start, rx_data, busy, frame_done, frame_err
   );
endinterface

// File: rtl/eth_frame_sched.sv
// Round-robin Ethernet frame scheduler: builds preamble/SFD/MACs/length/payload/FCS.
// All outputs are registered; a payload byte accepted with pl_ready appears on rx_data the next cycle.
module eth_frame_sched #(
   parameter int unsigned N_REQ         = 2,
   parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
   parameter logic [47:0] SRC_MAC_ADDR  = 48'h00_0a_95_00_00_01
) (
   input logic             clk,
   input logic             rst,
   eth_frame_sched_if.slave bus
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_PREAMBLE, S_SFD, S_MACDST,
      S_MACSRC, S_PLLEN, S_PL, S_FCS, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      cnt_q, len_q;
   logic [7:0]       sum_q;
   logic             under_q;
   logic [IDX_W-1:0] sel_q, last_q;

   logic [IDX_W-1:0] win_c;
   logic             any_req_c;
   logic [7:0]       byte_c;
   logic             sum_en_c, under_c, busy_c;
   logic [N_REQ-1:0] onehot_c, gnt_c, pl_ready_d;

   logic             rx_start_q, busy_q, frame_done_q, frame_err_q;
   logic [7:0]       rx_data_q;
   logic [N_REQ-1:0] gnt_q, pl_ready_q;

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
      return IDX_W'((32'(base) + off) % N_REQ);
   endfunction

   // Round-robin winner: nearest requester after the last granted one.
   always_comb begin
      any_req_c = |bus.frm_req;
      win_c     = last_q;
      for (int unsigned off = N_REQ; off > 0; off--) begin
         if (bus.frm_req[rr_idx(last_q, off)]) win_c = rr_idx(last_q, off);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (bus.rx_ready && any_req_c) state_d = S_START;
         S_START:    state_d = S_PREAMBLE;
         S_PREAMBLE: if (cnt_q == 16'd6) state_d = S_SFD;
         S_SFD:      state_d = S_MACDST;
         S_MACDST:   if (cnt_q == 16'd5) state_d = S_MACSRC;
         S_MACSRC:   if (cnt_q == 16'd5) state_d = S_PLLEN;
         S_PLLEN:    if (cnt_q == 16'd1) state_d = (len_q == 16'd0) ? S_FCS : S_PL;
         S_PL:       if (cnt_q == len_q - 16'd1) state_d = S_FCS;
         S_FCS:      if (cnt_q == 16'd3) state_d = S_DONE;
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output decode: byte for the current state plus lookahead payload ready.
   always_comb begin
      byte_c     = 8'h00;
      sum_en_c   = 1'b0;
      under_c    = 1'b0;
      onehot_c   = N_REQ'(1) << sel_q;
      gnt_c      = '0;
      busy_c     = (state_q != S_IDLE);
      pl_ready_d = (state_d == S_PL) ? onehot_c : '0;
      unique case (state_q)
         S_START:    gnt_c = onehot_c;
         S_PREAMBLE: begin gnt_c = onehot_c; byte_c = 8'hAA; end
         S_SFD:      begin gnt_c = onehot_c; byte_c = 8'hAB; end
         S_MACDST: begin
            gnt_c    = onehot_c;
            sum_en_c = 1'b1;
            byte_c   = 8'(DEST_MAC_ADDR >> {cnt_q[2:0], 3'b000});
         end
         S_MACSRC: begin
            gnt_c    = onehot_c;
            sum_en_c = 1'b1;
            byte_c   = 8'(SRC_MAC_ADDR >> {cnt_q[2:0], 3'b000});
         end
         S_PLLEN: begin
            gnt_c    = onehot_c;
            sum_en_c = 1'b1;
            byte_c   = cnt_q[0] ? len_q[7:0] : len_q[15:8];
         end
         S_PL: begin
            gnt_c    = onehot_c;
            sum_en_c = 1'b1;
            under_c  = !bus.pl_valid[sel_q];
            byte_c   = under_c ? 8'h00 : 8'(bus.pl_data >> {sel_q, 3'b000});
         end
         S_FCS: begin
            gnt_c  = onehot_c;
            byte_c = 8'(~sum_q + 8'd1);
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         len_q        <= '0;
         sum_q        <= '0;
         under_q      <= 1'b0;
         sel_q        <= '0;
         last_q       <= LAST_RST;
         rx_start_q   <= 1'b0;
         rx_data_q    <= 8'h00;
         gnt_q        <= '0;
         pl_ready_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         cnt_q <= (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
         if (state_q == S_IDLE && state_d == S_START) begin
            sel_q <= win_c;
            len_q <= 16'(bus.frm_len >> {win_c, 4'b0000});
         end
         if (sum_en_c)                sum_q <= sum_q + byte_c;
         else if (state_q == S_DONE)  sum_q <= 8'h00;
         if (under_c)                 under_q <= 1'b1;
         else if (state_q == S_DONE)  under_q <= 1'b0;
         if (state_q == S_DONE)       last_q <= sel_q;
         rx_start_q   <= (state_q == S_START);
         rx_data_q    <= byte_c;
         gnt_q        <= gnt_c;
         pl_ready_q   <= pl_ready_d;
         busy_q       <= busy_c;
         frame_done_q <= (state_q == S_DONE);
         frame_err_q  <= (state_q == S_DONE) && under_q;
      end
   end

   assign bus.rx_start   = rx_start_q;
   assign bus.rx_data    = rx_data_q;
   assign bus.gnt        = gnt_q;
   assign bus.pl_ready   = pl_ready_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_eth_frame_sched.sv
// Directed bench for eth_frame_sched: captures whole frames and checks them
// against hand-computed header, payload and FCS bytes.
module tb_eth_frame_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   eth_frame_sched_if #(.N_REQ(2)) bus ();

   eth_frame_sched #(.N_REQ(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // Requester model state.
   logic [7:0] pbase [2];
   logic [7:0] pidx  [2];
   logic       auto_drop = 1'b0;
   logic       drop_en   = 1'b0;
   logic       drop_idx  = 1'b0;
   int         rdy_seen  = 0;

   // Captured frame.
   logic [7:0] fb [$];
   int         cyc;
   int         n_start;
   logic [1:0] got_gnt;
   logic [1:0] rdy_any;
   logic       got_err;

   // Common header bytes; indices 21/22 (length) are overridden per frame.
   logic [7:0] hdr [23] = '{8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAB,
                            8'h16, 8'h68, 8'h9D, 8'h95, 8'h0A, 8'h00,
                            8'h01, 8'h00, 8'h00, 8'h95, 8'h0A, 8'h00,
                            8'h00, 8'h00};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: update requester model from the handshake of the cycle just ended.
   task automatic tick();
      logic [1:0] xfer;
      xfer = bus.pl_ready & bus.pl_valid;
      if (bus.pl_ready[drop_idx] === 1'b1) rdy_seen++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (xfer[i] === 1'b1) pidx[i] = pidx[i] + 8'd1;
      if (auto_drop) bus.frm_req = bus.frm_req & ~bus.gnt;
      bus.pl_valid = 2'b11;
      if (drop_en && bus.pl_ready[drop_idx] === 1'b1 && rdy_seen == 2)
         bus.pl_valid[drop_idx] = 1'b0;
      bus.pl_data = {pbase[1] + pidx[1], pbase[0] + pidx[0]};
   endtask

   // Wait for rx_start, then record bytes up to the frame_done cycle (left current on return).
   task automatic capture(input string tag);
      int w;
      fb.delete();
      cyc = 0; n_start = 0; rdy_any = '0; got_gnt = '0; got_err = 1'b0; w = 0;
      while (bus.rx_start !== 1'b1 && w < 60) begin tick(); w++; end
      if (bus.rx_start !== 1'b1) begin
         chk({tag, "_start_timeout"}, 32'(bus.rx_start), 32'd1);
         return;
      end
      got_gnt = bus.gnt;
      while (bus.frame_done !== 1'b1 && cyc < 80) begin
         fb.push_back(bus.rx_data);
         n_start += int'(bus.rx_start);
         rdy_any |= bus.pl_ready;
         cyc++;
         tick();
      end
      cyc++;
      got_err = bus.frame_err;
      chk({tag, "_done_seen"}, 32'(bus.frame_done), 32'd1);
   endtask

   task automatic chk_hdr(input string tag, input logic [7:0] lhi, input logic [7:0] llo);
      logic [7:0] e;
      for (int i = 0; i < 23; i++) begin
         e = (i == 21) ? lhi : (i == 22) ? llo : hdr[i];
         chk($sformatf("%s_hdr%0d", tag, i), 32'(fb[i]), 32'(e));
      end
   endtask

   task automatic new_test(input logic [7:0] b0, input logic [7:0] b1);
      pbase[0] = b0; pbase[1] = b1;
      pidx[0] = 8'd0; pidx[1] = 8'd0;
      rdy_seen = 0;
      bus.pl_data = {b1, b0};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd;
      bus.frm_req  = '0;
      bus.frm_len  = '0;
      bus.pl_valid = 2'b11;
      bus.rx_ready = 1'b0;
      new_test(8'h00, 8'h00);

      // Reset values.
      tick(); tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
      chk("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
      chk("rst_done", 32'(bus.frame_done), 32'd0);
      chk("rst_start", 32'(bus.rx_start), 32'd0);
      rst = 1'b0;

      // Receiver busy: requests pending but no grant.
      bus.frm_req = 2'b11;
      bus.frm_len = {16'd1, 16'd1};
      new_test(8'h40, 8'h50);
      for (int i = 0; i < 6; i++) tick();
      chk("rxbusy_gnt", 32'(bus.gnt), 32'd0);
      chk("rxbusy_busy", 32'(bus.busy), 32'd0);

      // Contention: order 0,1,0, len=1.
      bus.rx_ready = 1'b1;
      capture("cont0");
      chk("cont0_gnt", 32'(got_gnt), 32'h1);
      chk("cont0_pl", 32'(fb[23]), 32'h40);
      chk("cont0_fcs", 32'(fb[24]), 32'h65);
      capture("cont1");
      chk("cont1_gnt", 32'(got_gnt), 32'h2);
      chk("cont1_pl", 32'(fb[23]), 32'h50);
      chk("cont1_fcs", 32'(fb[24]), 32'h55);
      capture("cont2");
      bus.frm_req = '0;
      chk("cont2_gnt", 32'(got_gnt), 32'h1);
      chk("cont2_pl", 32'(fb[23]), 32'h41);
      chk("cont2_fcs", 32'(fb[24]), 32'h64);
      chk_hdr("cont2", 8'h00, 8'h01);

      // Single frame: req0, len=3, payload 01 02 03.
      auto_drop = 1'b1;
      tick();
      new_test(8'h01, 8'h00);
      bus.frm_len = {16'd7, 16'd3};
      bus.frm_req = 2'b01;
      capture("single");
      chk("single_gnt", 32'(got_gnt), 32'h1);
      chk("single_cycles", 32'(cyc), 32'd31);
      chk("single_nbytes", 32'(fb.size()), 32'd30);
      chk("single_nstart", 32'(n_start), 32'd1);
      chk_hdr("single", 8'h00, 8'h03);
      chk("single_pl0", 32'(fb[23]), 32'h01);
      chk("single_pl1", 32'(fb[24]), 32'h02);
      chk("single_pl2", 32'(fb[25]), 32'h03);
      for (int i = 26; i < 30; i++) chk($sformatf("single_fcs%0d", i - 26), 32'(fb[i]), 32'h9D);
      chk("single_err", 32'(got_err), 32'd0);
      chk("single_rdy_mask", 32'(rdy_any), 32'h1);

      // Underrun: req1, len=4, valid dropped on the 3rd payload cycle.
      tick();
      new_test(8'h00, 8'h10);
      drop_en = 1'b1; drop_idx = 1'b1;
      bus.frm_len = {16'd4, 16'd9};
      bus.frm_req = 2'b10;
      capture("under");
      drop_en = 1'b0; drop_idx = 1'b0;
      chk("under_gnt", 32'(got_gnt), 32'h2);
      chk("under_cycles", 32'(cyc), 32'd32);
      chk("under_len", 32'({fb[21], fb[22]}), 32'h0004);
      chk("under_pl0", 32'(fb[23]), 32'h10);
      chk("under_pl1", 32'(fb[24]), 32'h11);
      chk("under_pl2", 32'(fb[25]), 32'h00);
      chk("under_pl3", 32'(fb[26]), 32'h12);
      chk("under_fcs", 32'(fb[27]), 32'h6F);
      chk("under_fcs_last", 32'(fb[30]), 32'h6F);
      chk("under_err", 32'(got_err), 32'd1);
      chk("under_rdy_mask", 32'(rdy_any), 32'h2);

      // Zero length: length bytes straight into FCS, no pl_ready.
      tick();
      new_test(8'h01, 8'h00);
      bus.frm_len = {16'd5, 16'd0};
      bus.frm_req = 2'b01;
      capture("zero");
      chk("zero_gnt", 32'(got_gnt), 32'h1);
      chk("zero_cycles", 32'(cyc), 32'd28);
      chk_hdr("zero", 8'h00, 8'h00);
      for (int i = 23; i < 27; i++) chk($sformatf("zero_fcs%0d", i - 23), 32'(fb[i]), 32'hA6);
      chk("zero_rdy", 32'(rdy_any), 32'h0);
      chk("zero_err", 32'(got_err), 32'd0);

      // Reset during payload aborts the frame.
      tick();
      new_test(8'h30, 8'h00);
      bus.frm_len = {16'd0, 16'd6};
      bus.frm_req = 2'b01;
      nd = 0;
      while (bus.pl_ready[0] !== 1'b1 && nd < 60) begin tick(); nd++; end
      chk("abort_reached_pl", 32'(bus.pl_ready[0]), 32'd1);
      rst = 1'b1;
      tick();
      chk("abort_gnt", 32'(bus.gnt), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_rx_data", 32'(bus.rx_data), 32'h00);
      chk("abort_pl_ready", 32'(bus.pl_ready), 32'd0);
      chk("abort_done", 32'(bus.frame_done), 32'd0);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         nd += int'(bus.frame_done === 1'b1);
      end
      chk("abort_no_done", 32'(nd), 32'd0);
      chk("abort_idle_busy", 32'(bus.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
